// File: rtl/serial_pkg.sv
// Types and constants shared by the serial transmitter and receiver.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam bit MSB_FIRST = 1'b0;
  localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/bit_counter.sv
// Mod-N bit counter with enable, synchronous clear and terminal-count flag.
module bit_counter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 clr_i,
  output logic [$clog2(N)-1:0] cnt_o,
  output logic                 tc_o
);

  localparam int unsigned CW = $clog2(N);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == CW'(N - 1));
  assign cnt_o = cnt_q;

  // Clear wins over enable so a new frame always starts from bit 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word in, one bit per enabled
// cycle out, back-to-back frames without an idle bit.
module piso_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             pi_valid,
  output logic             pi_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt;
  logic             cnt_tc;
  logic             frame_end;
  logic             accept;

  assign frame_end = (state_q == SHIFT) && cnt_tc && shift_en;
  assign accept    = pi_valid && pi_ready;

  bit_counter #(.N(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .en_i  ((state_q == SHIFT) && shift_en),
    .clr_i (accept || frame_end),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

  // The outgoing bit always sits at the sr_q edge that sout taps, so sout is a
  // flop output; clearing sr_q on the way to IDLE keeps the idle line at 0.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sr_d    = pi;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_tc) begin
            if (pi_valid) begin
              sr_d = pi;
            end else begin
              state_d = IDLE;
              sr_d    = '0;
            end
          end else if (LSB_FIRST != MSB_FIRST) begin
            sr_d = sr_q >> 1;
          end else begin
            sr_d = sr_q << 1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = '0;
      end
    endcase
  end

  always_comb begin
    pi_ready   = (state_q == IDLE) || frame_end;
    sout_valid = (state_q == SHIFT);
    busy       = (state_q == SHIFT);
    sout_last  = (state_q == SHIFT) && (cnt == CW'(WIDTH - 1));
    sout       = (LSB_FIRST != MSB_FIRST) ? sr_q[0] : sr_q[WIDTH-1];
  end

endmodule
